// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one memory port between an I-cache (read-only line fills) and a
//   D-cache (line fills and writebacks). While the memory port is idle, a
//   pending request wins the grant. When both sides are pending, the grant
//   alternates between them, starting with D after reset. A granted transfer
//   runs until pmem_resp and is never pre-empted.
//
// Ports
//   clk, rst                          clock; asynchronous active-high reset
//   inst_read, inst_addr              I-cache fill request and line address
//   inst_rdata, inst_resp             I-cache fill data and completion pulse
//   data_read, data_write, data_addr  D-cache fill/writeback request and address
//   data_wdata                        D-cache writeback data
//   data_rdata, data_resp             D-cache fill data and completion pulse
//   pmem_read, pmem_write             shared memory request strobes
//   pmem_addr, pmem_wdata             shared memory address and write data
//   pmem_rdata, pmem_resp             shared memory read data and completion

module cache_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_read,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [LINE_W-1:0] inst_rdata,
    output logic              inst_resp,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [LINE_W-1:0] data_wdata,
    output logic [LINE_W-1:0] data_rdata,
    output logic              data_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeD
    } state_e;

    state_e r_state;
    logic   r_last_grant;  // 0 = I granted last, 1 = D granted last
    logic   w_d_pend;

    assign w_d_pend = data_read | data_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    // D wins a tie unless it won the previous grant.
                    if (w_d_pend && (!inst_read || !r_last_grant)) begin
                        r_state      <= StServeD;
                        r_last_grant <= 1'b1;
                    end else if (inst_read) begin
                        r_state      <= StServeI;
                        r_last_grant <= 1'b0;
                    end
                end
                // Held until memory completes, even if the requester drops.
                StServeI, StServeD: begin
                    if (pmem_resp) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        inst_resp  = 1'b0;
        data_resp  = 1'b0;
        case (r_state)
            StServeI: begin
                pmem_read = 1'b1;
                pmem_addr = inst_addr;
                inst_resp = pmem_resp;
            end
            StServeD: begin
                // A writeback takes priority if both strobes are up.
                pmem_write = data_write;
                pmem_read  = data_read & ~data_write;
                pmem_addr  = data_addr;
                pmem_wdata = data_wdata;
                data_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; resp tells each cache when it is valid.
    assign inst_rdata = pmem_rdata;
    assign data_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_read;
    logic [AW-1:0] inst_addr;
    logic [LW-1:0] inst_rdata;
    logic          inst_resp;
    logic          data_read;
    logic          data_write;
    logic [AW-1:0] data_addr;
    logic [LW-1:0] data_wdata;
    logic [LW-1:0] data_rdata;
    logic          data_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_arbiter #(
        .LINE_W(LW),
        .ADDR_W(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_read (inst_read),
        .inst_addr (inst_addr),
        .inst_rdata(inst_rdata),
        .inst_resp (inst_resp),
        .data_read (data_read),
        .data_write(data_write),
        .data_addr (data_addr),
        .data_wdata(data_wdata),
        .data_rdata(data_rdata),
        .data_resp (data_resp),
        .pmem_read (pmem_read),
        .pmem_write(pmem_write),
        .pmem_addr (pmem_addr),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp (pmem_resp)
    );

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " idle rd"}, LW'(pmem_read), LW'(0));
        chk({nm, " idle wr"}, LW'(pmem_write), LW'(0));
        chk({nm, " idle addr"}, LW'(pmem_addr), LW'(0));
        chk({nm, " idle wdata"}, pmem_wdata, LW'(0));
        chk({nm, " idle iresp"}, LW'(inst_resp), LW'(0));
        chk({nm, " idle dresp"}, LW'(data_resp), LW'(0));
    endtask

    task automatic clear_reqs();
        inst_read  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    // Called at the negedge where requests are applied (or the idle negedge
    // after a previous transfer). The grant must show on the next negedge.
    task automatic xfer(input string nm, input bit exp_d, input bit exp_rd, input bit exp_wr,
                        input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_wd,
                        input int lat, input bit drop);
        logic [LW-1:0] pat;
        @(negedge clk); #1;
        chk({nm, " rd"}, LW'(pmem_read), LW'(exp_rd));
        chk({nm, " wr"}, LW'(pmem_write), LW'(exp_wr));
        chk({nm, " addr"}, LW'(pmem_addr), LW'(exp_addr));
        chk({nm, " wdata"}, pmem_wdata, exp_wd);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk); #1;
            chk({nm, " hold"}, LW'({pmem_read, pmem_write}), LW'({exp_rd, exp_wr}));
            chk({nm, " early resp"}, LW'({inst_resp, data_resp}), LW'(0));
        end
        @(negedge clk);
        pat = {8{$urandom}};
        pmem_rdata = pat;
        pmem_resp  = 1'b1;
        #1;
        chk({nm, " iresp"}, LW'(inst_resp), LW'(!exp_d));
        chk({nm, " dresp"}, LW'(data_resp), LW'(exp_d));
        chk({nm, " irdata"}, inst_rdata, pat);
        chk({nm, " drdata"}, data_rdata, pat);
        @(negedge clk);
        pmem_resp = 1'b0;
        if (drop) clear_reqs();
        #1;
        chk_idle(nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        string         nm;
        bit            ir;
        bit            dr;
        bit            dw;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [LW-1:0] wd;
        int            lat;
        bit            exp_d;
        bit            exp_rd;
        bit            exp_wr;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [LW-1:0] a5;
        logic [LW-1:0] w1;
        a5 = {32{8'hA5}};
        w1 = LW'(256'h1234);

        rst        = 1'b1;
        clear_reqs();
        inst_addr  = '0;
        data_addr  = '0;
        data_wdata = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;

        //          name         ir dr dw ia           da           wd  lat D rd wr addr         wdata
        vecs[0] = '{"ifill",     1, 0, 0, 32'h0000_1000, 32'h0, '0, 4, 0, 1, 0, 32'h0000_1000, '0};
        vecs[1] = '{"dwrite",    0, 0, 1, 32'h0, 32'h0000_2040, a5, 3, 1, 0, 1, 32'h0000_2040, a5};
        vecs[2] = '{"dread",     0, 1, 0, 32'h0, 32'h0000_3000, w1, 2, 1, 1, 0, 32'h0000_3000, w1};
        vecs[3] = '{"drd_wr",    0, 1, 1, 32'h0, 32'h0000_4000, a5, 1, 1, 0, 1, 32'h0000_4000, a5};
        vecs[4] = '{"tie_i_dr",  1, 1, 0, 32'h0000_5000, 32'h0000_6000, w1, 2, 1, 1, 0,
                    32'h0000_6000, w1};
        vecs[5] = '{"tie_i_dw",  1, 0, 1, 32'h0000_7000, 32'h0000_8000, a5, 1, 1, 0, 1,
                    32'h0000_8000, a5};

        #2;
        chk_idle("async reset");
        do_reset();

        foreach (vecs[k]) begin
            do_reset();
            inst_read  = vecs[k].ir;
            data_read  = vecs[k].dr;
            data_write = vecs[k].dw;
            inst_addr  = vecs[k].ia;
            data_addr  = vecs[k].da;
            data_wdata = vecs[k].wd;
            xfer(vecs[k].nm, vecs[k].exp_d, vecs[k].exp_rd, vecs[k].exp_wr, vecs[k].exp_addr,
                 vecs[k].exp_wd, vecs[k].lat, 1'b1);
        end

        // Both sides held high: grants alternate D, I, D, I with one idle cycle between.
        do_reset();
        inst_read  = 1'b1;
        data_read  = 1'b1;
        inst_addr  = 32'h0000_A000;
        data_addr  = 32'h0000_B000;
        data_wdata = '0;
        xfer("alt1 D", 1'b1, 1'b1, 1'b0, 32'h0000_B000, '0, 2, 1'b0);
        xfer("alt2 I", 1'b0, 1'b1, 1'b0, 32'h0000_A000, '0, 1, 1'b0);
        xfer("alt3 D", 1'b1, 1'b1, 1'b0, 32'h0000_B000, '0, 3, 1'b0);
        xfer("alt4 I", 1'b0, 1'b1, 1'b0, 32'h0000_A000, '0, 1, 1'b1);

        // Requester drops mid-transfer and the other side shows up: no abort, no switch.
        do_reset();
        inst_read = 1'b1;
        inst_addr = 32'h0000_C000;
        data_addr = 32'h0000_D000;
        @(negedge clk); #1;
        chk("drop grant", LW'({pmem_read, pmem_addr}), LW'({1'b1, 32'h0000_C000}));
        inst_read = 1'b0;
        data_read = 1'b1;
        @(negedge clk); #1;
        chk("drop held", LW'({pmem_read, pmem_addr}), LW'({1'b1, 32'h0000_C000}));
        pmem_resp = 1'b1;
        #1;
        chk("drop resp", LW'({inst_resp, data_resp}), LW'(2'b10));
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk_idle("drop after");
        xfer("drop next D", 1'b1, 1'b1, 1'b0, 32'h0000_D000, '0, 1, 1'b1);

        // Reset two cycles into a writeback drops the strobe asynchronously.
        do_reset();
        data_write = 1'b1;
        data_read  = 1'b1;
        data_addr  = 32'h0000_E000;
        data_wdata = a5;
        @(negedge clk); #1;
        chk("rst xfer wr", LW'(pmem_write), LW'(1));
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst async wr", LW'(pmem_write), LW'(0));
        chk("rst async addr", LW'(pmem_addr), LW'(0));
        @(negedge clk);
        rst = 1'b0;
        data_write = 1'b0;
        xfer("rst rearb D", 1'b1, 1'b1, 1'b0, 32'h0000_E000, a5, 2, 1'b1);

        // Memory response while idle is ignored.
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        chk_idle("stray resp");
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk_idle("stray after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
